// File: rtl/grid_pkg.sv
// Shared types and helpers for the grid matrix scanner.
// Grid geometry, scan state encoding and a row-slice helper.
package grid_pkg;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int GRID_W = 64;
  localparam int ROW_W  = $clog2(ROWS);

  typedef enum logic {
    BLANK,
    DRIVE
  } scan_state_t;

  function automatic logic [COLS-1:0] row_slice(
    input logic [GRID_W-1:0] g,
    input logic [ROW_W-1:0]  r
  );
    return g[COLS*int'(r) +: COLS];
  endfunction

endpackage

// File: rtl/matrix_phase_timer.sv
// Loadable down-counter timing one scan phase (row drive or blank).
// Ports: clk, load/load_val (reload), last (final cycle of the phase).
module matrix_phase_timer #(
  parameter int MAX_CYCLES = 1000,
  parameter int CW = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1
) (
  input  logic          clk,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          last
);

  logic [CW-1:0] cnt;

  // load_val is phase length minus one; cnt==0 marks the final cycle
  always_ff @(posedge clk) begin
    if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign last = (cnt == '0);

endmodule

// File: rtl/grid_matrix_scanner.sv
// Double-buffered 8x8 LED matrix scanner fed by the 64-bit grid bus.
// Ports: clk, reset, grid/grid_valid in; row_sel, col_data, frame_start, pending_full out.
module grid_matrix_scanner
  import grid_pkg::*;
#(
  parameter int ROW_CYCLES     = 1000,
  parameter int BLANK_CYCLES   = 16,
  parameter bit ROW_ACTIVE_LOW = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GRID_W-1:0] grid,
  input  logic              grid_valid,
  output logic [ROWS-1:0]   row_sel,
  output logic [COLS-1:0]   col_data,
  output logic              frame_start,
  output logic              pending_full
);

  localparam int MAXC =
    (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int CW = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] ROW_LD   = CW'(ROW_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYCLES - 1);
  localparam logic [ROWS-1:0] IDLE =
    ROW_ACTIVE_LOW ? {ROWS{1'b1}} : {ROWS{1'b0}};

  scan_state_t       st, st_n;
  logic [ROW_W-1:0]  row_idx, row_n;
  logic [GRID_W-1:0] disp, disp_n;
  logic [GRID_W-1:0] pend, pend_n;
  logic              pf_n;
  logic [ROWS-1:0]   oh_n, rs_n;
  logic [COLS-1:0]   cd_n;
  logic              fs_n;
  logic              ld, last;
  logic [CW-1:0]     ld_val;

  matrix_phase_timer #(
    .MAX_CYCLES (MAXC),
    .CW         (CW)
  ) u_timer (
    .clk      (clk),
    .load     (ld),
    .load_val (ld_val),
    .last     (last)
  );

  always_comb begin
    st_n   = st;
    row_n  = row_idx;
    disp_n = disp;
    pend_n = pend;
    pf_n   = pending_full;
    ld     = 1'b0;
    ld_val = BLANK_LD;
    case (st)
      BLANK: begin
        if (last) begin
          st_n   = DRIVE;
          ld     = 1'b1;
          ld_val = ROW_LD;
          // frame boundary: only here may the shown image change
          if (row_idx == '0 && pending_full) begin
            disp_n = pend;
            pf_n   = 1'b0;
          end
        end
      end
      DRIVE: begin
        if (last) begin
          st_n   = BLANK;
          ld     = 1'b1;
          ld_val = BLANK_LD;
          row_n  = row_idx + 1'b1;
        end
      end
      default: ;
    endcase
    // a capture on the swap edge waits for the next frame
    if (grid_valid) begin
      pend_n = grid;
      pf_n   = 1'b1;
    end
    if (reset) begin
      ld     = 1'b1;
      ld_val = BLANK_LD;
    end
    oh_n = {{(ROWS-1){1'b0}}, 1'b1} << row_n;
    rs_n = IDLE;
    cd_n = '0;
    if (st_n == DRIVE) begin
      rs_n = ROW_ACTIVE_LOW ? ~oh_n : oh_n;
      cd_n = row_slice(disp_n, row_n);
    end
    fs_n = (st == BLANK) && (st_n == DRIVE) && (row_n == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st           <= BLANK;
      row_idx      <= '0;
      disp         <= '0;
      pend         <= '0;
      pending_full <= 1'b0;
      row_sel      <= IDLE;
      col_data     <= '0;
      frame_start  <= 1'b0;
    end else begin
      st           <= st_n;
      row_idx      <= row_n;
      disp         <= disp_n;
      pend         <= pend_n;
      pending_full <= pf_n;
      row_sel      <= rs_n;
      col_data     <= cd_n;
      frame_start  <= fs_n;
    end
  end

endmodule

// File: tb/tb_grid_matrix_scanner.sv
// Randomised self-checking bench for grid_matrix_scanner.
// Reference model derives the scan position from elapsed cycles.
module tb_grid_matrix_scanner;

  localparam int R = 4;
  localparam int B = 2;
  localparam int S = R + B;
  localparam int P = 8 * S;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] grid;
  logic        grid_valid;
  logic [7:0]  row_sel;
  logic [7:0]  col_data;
  logic        frame_start;
  logic        pending_full;

  int n_checks = 0;
  int n_errors = 0;

  int          k = 0;
  logic        seen = 1'b0;
  logic [63:0] m_disp = '0;
  logic [63:0] m_pend = '0;
  logic        m_pf = 1'b0;

  always #5 clk = ~clk;

  grid_matrix_scanner #(
    .ROW_CYCLES     (R),
    .BLANK_CYCLES   (B),
    .ROW_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .grid         (grid),
    .grid_valid   (grid_valid),
    .row_sel      (row_sel),
    .col_data     (col_data),
    .frame_start  (frame_start),
    .pending_full (pending_full)
  );

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s k=%0d got=%h exp=%h", tag, k, got, exp);
    end
  endtask

  // phase k counts edges since the last reset edge; the row-0
  // drive begins at phase B, which is also the swap edge
  task automatic model_edge();
    if (reset) begin
      k = 0;
      seen = 1'b1;
      m_disp = '0;
      m_pend = '0;
      m_pf = 1'b0;
    end else begin
      k++;
      if ((k % P) == B && m_pf) begin
        m_disp = m_pend;
        m_pf = 1'b0;
      end
      if (grid_valid) begin
        m_pend = grid;
        m_pf = 1'b1;
      end
    end
  endtask

  task automatic compare();
    int ph, rr, o;
    logic drv;
    logic [7:0] e_rs, e_cd, one;
    ph = k % P;
    rr = ph / S;
    o = ph % S;
    drv = (o >= B);
    one = 8'h01 << rr;
    e_rs = drv ? ~one : 8'hFF;
    e_cd = drv ? m_disp[8*rr +: 8] : 8'h00;
    check("row_sel", 64'(row_sel), 64'(e_rs));
    check("col_data", 64'(col_data), 64'(e_cd));
    check("frame_start", 64'(frame_start), 64'(ph == B));
    check("pending_full", 64'(pending_full), 64'(m_pf));
  endtask

  task automatic step(input logic r, input logic v,
                      input logic [63:0] g);
    reset = r;
    grid_valid = v;
    grid = g;
    @(posedge clk);
    model_edge();
    #1;
    if (seen) compare();
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd64());
  endtask

  // advance until the next edge lands on phase p
  task automatic wait_phase(input int p);
    for (int i = 0; i < P; i++) begin
      if (((k + 1) % P) == p) break;
      step(1'b0, 1'b0, rnd64());
    end
  endtask

  initial begin
    reset = 1'b1;
    grid_valid = 1'b0;
    grid = '0;
    // reset with grid_valid asserted: capture must be ignored
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, rnd64());
    step(1'b0, 1'b1, 64'h8040201008040201);
    idle(2 * P);
    // capture mid-frame during row 3 drive
    wait_phase(3 * S + B + 1);
    step(1'b0, 1'b1, 64'hFFFFFFFFFFFFFFFF);
    idle(2 * P);
    // last write wins
    wait_phase(2 * S);
    step(1'b0, 1'b1, 64'h00000000000000AA);
    idle(7);
    step(1'b0, 1'b1, 64'h0000000000000055);
    idle(P + S);
    // capture exactly on the swap edge
    wait_phase(5 * S);
    step(1'b0, 1'b1, 64'h000000000000000F);
    wait_phase(B);
    step(1'b0, 1'b1, 64'h00000000000000F0);
    idle(2 * P);
    // reset during row 5 drive
    wait_phase(5 * S + B + 1);
    step(1'b1, 1'b0, rnd64());
    idle(P + S);
    // random traffic with occasional resets
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 399) == 0,
           $urandom_range(0, 15) == 0,
           rnd64());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
